// File: rtl/audio_pkg.sv
// Shared constants and types for the codec audio capture path.
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int CNT_8KHZ    = 3;
  localparam int BIT_CNT_W   = 5;
  localparam int FRAME_CNT_W = 5;

  typedef enum logic {
    CH_LEFT,
    CH_RIGHT
  } channel_e;

endpackage

// File: rtl/audio_edge_det.sv
// Registered history of a slow codec clock with single-cycle
// rise/fall pulses in the system clock domain.
module audio_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic old_q;
  logic old_d;

  always_comb begin
    old_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) old_q <= 1'b0;
    else       old_q <= old_d;
  end

  assign rise = d & ~old_q;
  assign fall = ~d & old_q;

endmodule

// File: rtl/audio_capture.sv
// Left-justified stereo ADC deserializer with frame decimation
// and a valid/ack output stage with sticky overrun.
module audio_capture #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int CNT_8KHZ = audio_pkg::CNT_8KHZ
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                bclk,
  input  logic                adc_lr_clk,
  input  logic                adc_dat,
  input  logic [2:0]          rate,
  output logic [SAMPLE_W-1:0] left_out,
  output logic [SAMPLE_W-1:0] right_out,
  output logic                data_valid,
  input  logic                data_ack,
  output logic                overrun
);

  import audio_pkg::*;

  localparam logic [BIT_CNT_W-1:0] BIT_FULL = BIT_CNT_W'(SAMPLE_W);

  logic bclk_rise, lr_rise, lr_fall;
  logic unused_bclk_fall;

  audio_edge_det u_bclk (
    .clk   (clk),
    .reset (reset),
    .d     (bclk),
    .rise  (bclk_rise),
    .fall  (unused_bclk_fall)
  );

  audio_edge_det u_lr (
    .clk   (clk),
    .reset (reset),
    .d     (adc_lr_clk),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  channel_e               ch_q, ch_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0]    shift_q, shift_d;
  logic                   left_ok_q, left_ok_d;
  logic                   sync_q, sync_d;
  logic [SAMPLE_W-1:0]    left_hold_q, left_hold_d;
  logic [SAMPLE_W-1:0]    right_hold_q, right_hold_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0]    left_out_q, left_out_d;
  logic [SAMPLE_W-1:0]    right_out_q, right_out_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic [SAMPLE_W-1:0]    word;
  logic [2:0]             rate_eff;
  logic [FRAME_CNT_W-1:0] div_m1;
  logic                   publish;

  assign rate_eff = (rate == 3'd0) ? 3'd1 : rate;
  assign div_m1   = FRAME_CNT_W'(CNT_8KHZ * int'(rate_eff) - 1);

  always_comb begin
    ch_d         = ch_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_ok_d    = left_ok_q;
    sync_d       = sync_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    publish      = 1'b0;
    word         = '0;
    if (!enable) begin
      bit_cnt_d   = '0;
      left_ok_d   = 1'b0;
      sync_d      = 1'b0;
      frame_cnt_d = '0;
    end else begin
      // lr edge first so a coincident bit lands as the new MSB
      if (lr_rise) begin
        ch_d      = CH_LEFT;
        bit_cnt_d = '0;
        shift_d   = '0;
        left_ok_d = 1'b0;
        sync_d    = 1'b1;
      end else if (lr_fall) begin
        ch_d      = CH_RIGHT;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
      if (bclk_rise && sync_d && bit_cnt_d < BIT_FULL) begin
        word      = {shift_d[SAMPLE_W-2:0], adc_dat};
        shift_d   = word;
        bit_cnt_d = bit_cnt_d + 1'b1;
        if (bit_cnt_d == BIT_FULL) begin
          if (ch_d == CH_LEFT) begin
            left_hold_d = word;
            left_ok_d   = 1'b1;
          end else begin
            right_hold_d = word;
            frame_done_d = left_ok_d;
          end
        end
      end
      if (frame_done_q) begin
        if (frame_cnt_q >= div_m1) begin
          publish     = 1'b1;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (publish) begin
      if (!valid_q || data_ack) begin
        left_out_d  = left_hold_q;
        right_out_d = right_hold_q;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q         <= CH_LEFT;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_ok_q    <= 1'b0;
      sync_q       <= 1'b0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      left_out_q   <= '0;
      right_out_q  <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ch_q         <= ch_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_ok_q    <= left_ok_d;
      sync_q       <= sync_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      left_out_q   <= left_out_d;
      right_out_q  <= right_out_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign left_out   = left_out_q;
  assign right_out  = right_out_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_capture.sv
// Bench for audio_capture: table-driven frames with a scoreboard
// queue, plus hand-written handshake, reset and enable sequences.
module tb_audio_capture;

  logic        clk = 1'b0;
  logic        reset, enable, bclk, adc_lr_clk, adc_dat, data_ack;
  logic [2:0]  rate;
  logic [15:0] left_out, right_out;
  logic        data_valid, overrun;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [2:0]  rate;
    logic [15:0] l;
    logic [15:0] r;
    bit          pub;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  audio_capture dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bclk       (bclk),
    .adc_lr_clk (adc_lr_clk),
    .adc_dat    (adc_dat),
    .rate       (rate),
    .left_out   (left_out),
    .right_out  (right_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .overrun    (overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_lr"}, {left_out, right_out}, 32'h0);
    chk({nm, "_flags"}, {30'd0, data_valid, overrun}, 32'h0);
  endtask

  // lr edge coincides with the first bclk rise of every slot
  task automatic send_slot(input bit lr, input logic [15:0] w,
                           input int mode);
    logic [15:0] sh;
    sh = w;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bclk    = 1'b0;
      adc_dat = sh[15];
      sh      = sh << 1;
      @(negedge clk);
      bclk = 1'b1;
      if (i == 0) adc_lr_clk = lr;
      if (mode == 1 && i == 15) begin
        @(negedge clk);
        chk("lat_k", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        chk("lat_k1", {31'd0, data_valid}, 32'd1);
      end
      if (mode == 2 && i == 15) begin
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
      end
      if (mode == 3 && i == 5) enable = 1'b0;
      if (mode == 4 && i == 4) enable = 1'b1;
      if (mode == 5 && i == 8) begin
        reset      = 1'b1;
        bclk       = 1'b0;
        adc_lr_clk = 1'b0;
        @(negedge clk);
        chk_zero("rst_during");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("rst_after");
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int rmode);
    send_slot(1'b1, l, 0);
    send_slot(1'b0, r, rmode);
  endtask

  task automatic drain(input bit do_ack, input string nm);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      repeat (2) @(negedge clk);
      chk({nm, "_nopub"}, {31'd0, data_valid}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      for (int t = 0; t < 300 && !data_valid; t++) @(negedge clk);
      chk({nm, "_dv"}, {31'd0, data_valid}, 32'd1);
      chk({nm, "_lr"}, {left_out, right_out}, e);
      chk({nm, "_ovr"}, {31'd0, overrun}, 32'd0);
      if (do_ack) begin
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chk({nm, "_ack"}, {31'd0, data_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{3'd1, 16'h0001, 16'h1001, 1'b0};
    tbl[1]  = '{3'd1, 16'h0002, 16'h1002, 1'b0};
    tbl[2]  = '{3'd1, 16'h0003, 16'h1003, 1'b1};
    tbl[3]  = '{3'd2, 16'h0100, 16'h0200, 1'b0};
    tbl[4]  = '{3'd2, 16'h0101, 16'h0201, 1'b0};
    tbl[5]  = '{3'd2, 16'h0102, 16'h0202, 1'b0};
    tbl[6]  = '{3'd2, 16'h0103, 16'h0203, 1'b0};
    tbl[7]  = '{3'd1, 16'h8001, 16'h7FFE, 1'b1};
    tbl[8]  = '{3'd0, 16'hFFFF, 16'h0000, 1'b0};
    tbl[9]  = '{3'd0, 16'h0000, 16'hFFFF, 1'b0};
    tbl[10] = '{3'd0, 16'h8000, 16'h0001, 1'b1};

    reset      = 1'b1;
    enable     = 1'b1;
    bclk       = 1'b0;
    adc_lr_clk = 1'b0;
    adc_dat    = 1'b0;
    data_ack   = 1'b0;
    rate       = 3'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    send_frame(16'h0011, 16'h0022, 0);
    drain(1'b1, "t1f0");
    send_frame(16'h0033, 16'h0044, 0);
    drain(1'b1, "t1f1");
    exp_q.push_back({16'hA5C3, 16'h1234});
    send_frame(16'hA5C3, 16'h1234, 1);
    drain(1'b1, "t1");

    for (int i = 0; i < 11; i++) begin
      rate = tbl[i].rate;
      if (tbl[i].pub) exp_q.push_back({tbl[i].l, tbl[i].r});
      send_frame(tbl[i].l, tbl[i].r, 0);
      drain(1'b1, $sformatf("v%0d", i));
    end

    rate = 3'd0;
    send_frame(16'h1357, 16'h2468, 0);
    send_frame(16'h1357, 16'h2468, 0);
    exp_q.push_back({16'h1357, 16'h2468});
    send_frame(16'h1357, 16'h2468, 0);
    drain(1'b0, "t4a");
    send_frame(16'h7777, 16'h8888, 0);
    send_frame(16'h7777, 16'h8888, 0);
    exp_q.push_back({16'h7777, 16'h8888});
    send_frame(16'h7777, 16'h8888, 2);
    drain(1'b1, "t4b");

    for (int k = 0; k < 3; k++) send_frame(16'hAAAA, 16'h5555, 0);
    exp_q.push_back({16'hAAAA, 16'h5555});
    drain(1'b0, "t3a");
    for (int k = 0; k < 3; k++) send_frame(16'h1111, 16'h2222, 0);
    @(negedge clk);
    chk("t3_dv", {31'd0, data_valid}, 32'd1);
    chk("t3_hold", {left_out, right_out}, {16'hAAAA, 16'h5555});
    chk("t3_ovr", {31'd0, overrun}, 32'd1);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    chk("t3_ack_dv", {31'd0, data_valid}, 32'd0);
    chk("t3_ack_ovr", {31'd0, overrun}, 32'd1);

    send_slot(1'b1, 16'hFFFF, 5);
    send_frame(16'hBEEF, 16'hCAFE, 0);
    drain(1'b1, "t5f0");
    send_frame(16'hBEEF, 16'hCAFE, 0);
    drain(1'b1, "t5f1");
    exp_q.push_back({16'hBEEF, 16'hCAFE});
    send_frame(16'hBEEF, 16'hCAFE, 0);
    drain(1'b1, "t5");

    send_frame(16'h0A0A, 16'h0B0B, 0);
    drain(1'b1, "t6p0");
    send_frame(16'h0A0A, 16'h0B0B, 0);
    drain(1'b1, "t6p1");
    send_slot(1'b1, 16'h0F0F, 3);
    send_slot(1'b0, 16'hF0F0, 4);
    drain(1'b1, "t6x");
    send_frame(16'h4321, 16'h8765, 0);
    drain(1'b1, "t6f0");
    send_frame(16'h4321, 16'h8765, 0);
    drain(1'b1, "t6f1");
    exp_q.push_back({16'h4321, 16'h8765});
    send_frame(16'h4321, 16'h8765, 0);
    drain(1'b1, "t6");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
